// File: rtl/fp_result_normalizer.sv
// rtl/fp_result_normalizer.sv - multi-cycle normalizer/packer for raw FP add/sub results
//
// Purpose:
//   Takes the unnormalized sign/exponent/mantissa produced by the add/sub datapath,
//   normalizes it one shift per clock, and presents it in packed operand format
//   (sign, EXP_W-bit exponent, MAN_W-bit mantissa with explicit integer bit at MAN_W-1).
//   Zero, exponent overflow (saturate) and exponent underflow (flush) are flagged.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   raw result present
//   in_ready   out  block can accept (IDLE and not in reset)
//   in_sgn     in   raw sign
//   in_exp     in   raw exponent, EXP_W+1 bits unsigned
//   in_man     in   raw mantissa, MAN_W+1 bits (top bit = carry, next = integer bit)
//   out_valid  out  packed result present
//   out_ready  in   consumer accepts
//   out_sgn    out  packed sign
//   out_exp    out  packed exponent, EXP_W bits
//   out_man    out  packed mantissa, MAN_W bits
//   out_zero   out  exact zero or flushed result
//   out_ovf    out  exponent overflow, result saturated
//   out_uf     out  exponent underflow, result flushed to zero (implies out_zero)
//
// Configuration:
//   FP_NORM_ROUND_EN  defined: the carry right-shift rounds to nearest even on the
//                     shifted-out bit; undefined: the shifted-out bit is truncated.

module fp_result_normalizer #(
  parameter int MAN_W = 10,
  parameter int EXP_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sgn,
  input  logic [EXP_W:0]   in_exp,
  input  logic [MAN_W:0]   in_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sgn,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_uf
);

  // Largest exponent the packed format can carry, in the wide (EXP_W+1) domain.
  localparam logic [EXP_W:0] EXP_LIM = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_SAT = {(EXP_W+1){1'b1}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
`ifdef FP_NORM_ROUND_EN
  localparam logic [MAN_W:0] MAN_ONE = {{MAN_W{1'b0}}, 1'b1};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic           sgn_q, zero_q, ovf_q, uf_q;
  logic [EXP_W:0] exp_q;
  logic [MAN_W:0] man_q;

  logic           sgn_d, zero_d, ovf_d, uf_d;
  logic [EXP_W:0] exp_d;
  logic [MAN_W:0] man_d;
  logic [MAN_W:0] shifted;
  logic           step_done;
  logic           accept;
  logic           done;

  assign accept = in_valid && in_ready;
  assign done   = (state == DONE);

  // One normalization step, evaluated on the working registers while in NORM.
  always_comb begin
    sgn_d     = sgn_q;
    exp_d     = exp_q;
    man_d     = man_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    uf_d      = uf_q;
    step_done = 1'b0;
    shifted   = {1'b0, man_q[MAN_W:1]};
    if (man_q == '0) begin
      // Exact zero: canonical positive zero.
      sgn_d     = 1'b0;
      exp_d     = '0;
      zero_d    = 1'b1;
      step_done = 1'b1;
    end else if (man_q[MAN_W]) begin
      // Carry out of the adder: one right shift. A rounding carry can set the
      // top bit again, which simply earns one more pass through this branch.
`ifdef FP_NORM_ROUND_EN
      if (man_q[0] && shifted[0]) begin
        shifted = shifted + MAN_ONE;
      end
`endif
      man_d = shifted;
      exp_d = (exp_q == EXP_SAT) ? EXP_SAT : exp_q + EXP_ONE;
    end else if (!man_q[MAN_W-1] && (exp_q != '0)) begin
      man_d = man_q << 1;
      exp_d = exp_q - EXP_ONE;
    end else if (!man_q[MAN_W-1]) begin
      // Ran out of exponent before the integer bit appeared: flush to zero.
      man_d     = '0;
      exp_d     = '0;
      sgn_d     = 1'b0;
      uf_d      = 1'b1;
      zero_d    = 1'b1;
      step_done = 1'b1;
    end else if (exp_q > EXP_LIM) begin
      // Normalized but not representable: saturate to the largest magnitude.
      exp_d     = EXP_LIM;
      man_d     = {1'b0, {MAN_W{1'b1}}};
      ovf_d     = 1'b1;
      step_done = 1'b1;
    end else begin
      step_done = 1'b1;
    end
  end

  // Working registers: loaded on accept, stepped in NORM, frozen in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q  <= 1'b0;
      exp_q  <= '0;
      man_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sgn_q  <= in_sgn;
            exp_q  <= in_exp;
            man_q  <= in_man;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            uf_q   <= 1'b0;
          end
        end
        NORM: begin
          sgn_q  <= sgn_d;
          exp_q  <= exp_d;
          man_q  <= man_d;
          zero_q <= zero_d;
          ovf_q  <= ovf_d;
          uf_q   <= uf_d;
        end
        default: begin
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = NORM;
      NORM:    if (step_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. Result fields are forced to zero outside DONE so nothing
  // half-normalized is ever visible and reset clears them immediately.
  always_comb begin
    in_ready  = (state == IDLE) && rst_n;
    out_valid = done;
    out_sgn   = done ? sgn_q : 1'b0;
    out_exp   = done ? exp_q[EXP_W-1:0] : '0;
    out_man   = done ? man_q[MAN_W-1:0] : '0;
    out_zero  = done ? zero_q : 1'b0;
    out_ovf   = done ? ovf_q : 1'b0;
    out_uf    = done ? uf_q : 1'b0;
  end

endmodule

// File: tb/tb_fp_result_normalizer.sv
// tb/tb_fp_result_normalizer.sv - self-checking bench for fp_result_normalizer

module tb_fp_result_normalizer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_sgn;
  logic [5:0] in_exp;
  logic [10:0] in_man;
  logic       out_valid;
  logic       out_ready;
  logic       out_sgn;
  logic [4:0] out_exp;
  logic [9:0] out_man;
  logic       out_zero;
  logic       out_ovf;
  logic       out_uf;

  int total = 0;
  int bad   = 0;

  fp_result_normalizer #(.MAN_W(10), .EXP_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sgn(in_sgn), .in_exp(in_exp), .in_man(in_man),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sgn(out_sgn), .out_exp(out_exp), .out_man(out_man),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_uf(out_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {sgn, exp[4:0], man[9:0], zero, ovf, uf}
  function automatic logic [18:0] obs();
    return {out_sgn, out_exp, out_man, out_zero, out_ovf, out_uf};
  endfunction

  // Reference model: value-level normalization computed in closed form.
  task automatic model(input int s, input int e, input int m,
                       output logic [18:0] res, output int lat);
    int steps;
    int sh;
    int q;
    steps = 0;
    if (m == 0) begin
      res = {1'b0, 5'd0, 10'd0, 3'b100};
      lat = 1;
      return;
    end
    if (m >= 1024) begin
      q = m / 2;
`ifdef FP_NORM_ROUND_EN
      if ((m % 2) == 1 && (q % 2) == 1) q = q + 1;
`endif
      m = q;
      e = (e + 1 > 63) ? 63 : e + 1;
      steps++;
      if (m >= 1024) begin
        m = m / 2;
        e = (e + 1 > 63) ? 63 : e + 1;
        steps++;
      end
    end
    sh = 0;
    while (m < 512) begin
      m = m * 2;
      sh++;
    end
    if (sh > e) begin
      res = {1'b0, 5'd0, 10'd0, 3'b101};
      lat = e + 1;
      return;
    end
    e = e - sh;
    steps += sh;
    lat = steps + 1;
    if (e > 31) res = {s[0], 5'd31, 10'h3FF, 3'b010};
    else        res = {s[0], e[4:0], m[9:0], 3'b000};
  endtask

  // Driver: one transaction, returns the observed result and edges to out_valid.
  // Starts and ends aligned to a falling edge.
  task automatic do_op(input int s, input int e, input int m, input bit release_out,
                       output logic [18:0] res, output int lat);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    in_sgn   = s[0];
    in_exp   = e[5:0];
    in_man   = m[10:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    res = obs();
    if (release_out) begin
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_sgn = 1'b0; in_exp = '0; in_man = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, in_ready, obs()} !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {out_valid, in_ready, obs()});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    int ts[10] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 1};
    int te[10] = '{10, 10, 5, 20, 9, 3, 31, 63, 0, 9};
    int tm[10] = '{'h200, 'h500, 'h7FF, 'h010, 'h000, 'h001, 'h400, 'h400, 'h200, 'h001};
    logic [18:0] got, exp_r;
    int lat, exp_lat;
    for (int i = 0; i < 10; i++) begin
      model(ts[i], te[i], tm[i], exp_r, exp_lat);
      do_op(ts[i], te[i], tm[i], 1'b1, got, lat);
      total++;
      if (got !== exp_r) begin
        bad++;
        $display("FAIL directed_%0d_result: got %h want %h", i, got, exp_r);
      end
      total++;
      if (lat != exp_lat) begin
        bad++;
        $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] got;
    int lat;
    do_op(0, 20, 'h010, 1'b0, got, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      total++;
      if ({out_valid, in_ready, obs()} !== {2'b10, got}) begin
        bad++;
        $display("FAIL hold_cycle_%0d: got %h want %h", c, {out_valid, in_ready, obs()}, {2'b10, got});
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL hold_release: got %b want 01", {out_valid, in_ready});
    end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [18:0] got, exp_r;
    int lat, exp_lat;
    in_sgn = 1'b0; in_exp = 6'd20; in_man = 11'h010; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, obs()} !== 21'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h want 0", {out_valid, in_ready, obs()});
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    model(1, 10, 'h200, exp_r, exp_lat);
    do_op(1, 10, 'h200, 1'b1, got, lat);
    total++;
    if (got !== exp_r || lat != exp_lat) begin
      bad++;
      $display("FAIL midreset_recover: got %h/%0d want %h/%0d", got, lat, exp_r, exp_lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] got, exp_r;
    int lat, exp_lat;
    do_op(0, 10, 'h500, 1'b0, got, lat);
    model(1, 40, 'h0C3, exp_r, exp_lat);
    in_sgn = 1'b1; in_exp = 6'd40; in_man = 11'h0C3;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_handoff: got %b want 01", {out_valid, in_ready});
    end
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_busy: got %b want 0", in_ready);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    total++;
    if (obs() !== exp_r || lat != exp_lat) begin
      bad++;
      $display("FAIL b2b_second: got %h/%0d want %h/%0d", obs(), lat, exp_r, exp_lat);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [18:0] got, exp_r;
    int lat, exp_lat, s, e, m;
    for (int i = 0; i < 60; i++) begin
      s = int'($urandom_range(0, 1));
      e = int'($urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0: m = int'($urandom_range(0, 2047));
        1: m = int'($urandom_range(0, 15));
        2: m = int'($urandom_range(1024, 2047));
        default: m = int'($urandom_range(512, 1023));
      endcase
      model(s, e, m, exp_r, exp_lat);
      do_op(s, e, m, 1'b1, got, lat);
      total++;
      if (got !== exp_r || lat != exp_lat) begin
        bad++;
        $display("FAIL random_%0d s=%0d e=%0d m=%h: got %h/%0d want %h/%0d",
                 i, s, e, m, got, lat, exp_r, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
